// File: rtl/result_bram_stream_reader.sv
// result_bram_stream_reader
//
// Purpose:
//   Drains the FP16 result circular buffer. The buffer is 2**PTR_W FP16 entries
//   stored as 16 FP16 per BRAM line. This block fetches whole lines up to the
//   writer's pointer and unpacks them into a one-FP16-per-beat valid/ready
//   stream. As beats are accepted it advances the read pointer, which the
//   writer uses to free space.
//
// Ports:
//   i_clk           clock
//   i_reset         asynchronous active-high reset
//   i_wr_ptr        writer pointer (next free slot), registered before use
//   i_enable        permits new line fetches; never aborts a line in progress
//   i_flush         one-cycle pulse that discards all unread data
//   o_bram_rd_en    BRAM read strobe; data returns one cycle later
//   o_bram_rd_addr  BRAM line address; holds its last value between fetches
//   i_bram_rd_data  BRAM line; FP16 k sits at bits [16k+15:16k]
//   o_m_valid       stream valid
//   o_m_data        stream FP16 data
//   i_m_ready       stream ready
//   o_rd_ptr        read pointer (next slot to emit)
//   o_used_entries  (wr_q - rd_ptr) modulo 2**PTR_W
//   o_busy          high whenever the FSM is not idle
//
// Stream handshake: a beat transfers on a rising edge where o_m_valid and
// i_m_ready are both high. Once o_m_valid rises, o_m_valid and o_m_data hold
// until that transfer happens. The only exception is i_flush, which drops
// valid on the following cycle.

module result_bram_stream_reader #(
    parameter int PTR_W       = 13,
    parameter int LINE_ADDR_W = 9,
    parameter int LINE_W      = 256
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [PTR_W-1:0]       i_wr_ptr,
    input  logic                   i_enable,
    input  logic                   i_flush,
    output logic                   o_bram_rd_en,
    output logic [LINE_ADDR_W-1:0] o_bram_rd_addr,
    input  logic [LINE_W-1:0]      i_bram_rd_data,
    output logic                   o_m_valid,
    output logic [15:0]            o_m_data,
    input  logic                   i_m_ready,
    output logic [PTR_W-1:0]       o_rd_ptr,
    output logic [PTR_W-1:0]       o_used_entries,
    output logic                   o_busy
);

    localparam int WORD_IDX_W = PTR_W - LINE_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_STREAM
    } state_t;

    state_t                 state;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_q;
    logic [PTR_W-1:0]       snap;
    logic [LINE_W-1:0]      line_buf;
    logic [LINE_ADDR_W-1:0] rd_addr_q;

    logic [PTR_W-1:0]       rd_ptr_inc;
    logic [7:0]             word_bit;

    assign rd_ptr_inc = rd_ptr + PTR_W'(1);
    // Bit offset of the current FP16 within the buffered line.
    assign word_bit   = {rd_ptr[WORD_IDX_W-1:0], 4'b0000};

    assign o_bram_rd_en   = (state == ST_FETCH);
    assign o_bram_rd_addr = rd_addr_q;
    assign o_m_valid      = (state == ST_STREAM) && (rd_ptr != snap);
    assign o_m_data       = line_buf[word_bit +: 16];
    assign o_rd_ptr       = rd_ptr;
    assign o_used_entries = wr_q - rd_ptr;
    assign o_busy         = (state != ST_IDLE);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            rd_ptr    <= '0;
            wr_q      <= '0;
            snap      <= '0;
            line_buf  <= '0;
            rd_addr_q <= '0;
        end else begin
            // The writer commits its BRAM write one edge after its pointer
            // moves, so the registered copy only ever covers data that landed.
            wr_q <= i_wr_ptr;

            if (i_flush) begin
                // Takes priority over any handshake in the same cycle.
                rd_ptr <= wr_q;
                state  <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_enable && (rd_ptr != wr_q)) begin
                            // The address register doubles as the hold
                            // value seen outside FETCH.
                            rd_addr_q <= rd_ptr[PTR_W-1:WORD_IDX_W];
                            state     <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        // Freeze the emit limit for this line visit.
                        snap  <= wr_q;
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        line_buf <= i_bram_rd_data;
                        state    <= ST_STREAM;
                    end
                    ST_STREAM: begin
                        if (rd_ptr == snap) begin
                            // Nothing to emit; only reachable defensively.
                            state <= ST_IDLE;
                        end else if (i_m_ready) begin
                            rd_ptr <= rd_ptr_inc;
                            // Leave when the line is used up, or when the
                            // snapshot is reached (same line refetched later).
                            if ((rd_ptr_inc[WORD_IDX_W-1:0] == '0) ||
                                (rd_ptr_inc == snap)) begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
